// File: rtl/pistormx_pkg.sv
// Shared definitions for the PiStorm-X command queue: Pi register codes,
// control bit positions and the layout of one queued bus command.
package pistormx_pkg;

  // Pi register select codes carried on PI_A
  typedef enum logic [1:0] {
    REG_DATA    = 2'd0,
    REG_ADDR_LO = 2'd1,
    REG_ADDR_HI = 2'd2,
    REG_STATUS  = 2'd3
  } reg_sel_e;

  // Bit positions inside an ADDR_HI write
  localparam int HI_SZ_BIT = 8;
  localparam int HI_RW_BIT = 9;

  // Bit positions inside a STATUS write
  localparam int STATUS_OVF_CLR_BIT = 2;
  localparam int STATUS_FLUSH_BIT   = 3;

  // Queue entry width and field offsets (LSB first)
  localparam int ENTRY_W = 42;
  localparam int RW_OFS  = 0;
  localparam int SZ_OFS  = 1;
  localparam int A0_OFS  = 2;
  localparam int D_OFS   = 3;
  localparam int A_OFS   = 19;
  localparam int A_W     = 23;
  localparam int D_W     = 16;

  // One posted bus command; packed order matches the offsets above
  typedef struct packed {
    logic [A_W-1:0] a;
    logic [D_W-1:0] d;
    logic           a0;
    logic           sz;
    logic           rw;
  } cmd_entry_t;

  // Assemble a command from the staged low address/data and the ADDR_HI word
  function automatic cmd_entry_t make_entry(input logic [15:1] lo_addr,
                                            input logic        lo_a0,
                                            input logic [15:0] data,
                                            input logic [15:0] hi_word);
    cmd_entry_t e;
    e.a  = {hi_word[7:0], lo_addr};
    e.d  = data;
    e.a0 = lo_a0;
    e.sz = hi_word[HI_SZ_BIT];
    e.rw = hi_word[HI_RW_BIT];
    return e;
  endfunction

endpackage

// File: rtl/pistormx_cmd_fifo.sv
// DEPTH-entry FIFO of bus commands. Occupancy is kept as a DEPTH+1 state
// counter so full and empty never alias; pointers wrap naturally because
// DEPTH is a power of two. A push into a full FIFO succeeds only when the
// head is popped on the same clock, otherwise it is reported as dropped.
module pistormx_cmd_fifo
  import pistormx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  cmd_entry_t             wdata,
  output cmd_entry_t             rdata,
  output logic                   dropped,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  cmd_entry_t    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          pop_ok;
  logic          push_ok;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty & ~flush;
  assign push_ok = push & ~flush & (~full | pop_ok);
  assign dropped = push & ~flush & full & ~pop_ok;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the queue outright
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Entry storage, written only for accepted pushes
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/pistormx_cmd_queue.sv
// Command queue between the Pi GPIO register interface and the 68K bus
// engine. PI_WR is synchronised into the M68K_CLK domain, DATA/ADDR_LO
// writes are staged, and an ADDR_HI write commits a full command into the
// FIFO. Read completions are tracked so the Pi sees busy until data returns.
// Optional feature: define PISTORMX_QLEVEL_EN to expose the 'level' port.
module pistormx_cmd_queue
  import pistormx_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   M68K_CLK,
  input  logic                   M68K_RESET_n,
  input  logic [1:0]             PI_A,
  input  logic                   PI_WR,
  input  logic [15:0]            PI_D,
  output logic                   PI_TXN_IN_PROGRESS,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic [23:1]            cmd_a,
  output logic [15:0]            cmd_d,
  output logic                   cmd_a0,
  output logic                   cmd_sz,
  output logic                   cmd_rw,
  input  logic                   rd_valid,
  input  logic [15:0]            rd_data,
  output logic [15:0]            rd_buf,
  output logic                   overflow
`ifdef PISTORMX_QLEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] level
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [1:0]             rst_sync;
  logic                   rst_n;
  logic [SYNC_STAGES:0]   wr_sync;
  logic                   wr_pulse;
  logic [15:0]            stg_d;
  logic [15:1]            stg_a;
  logic                   stg_a0;
  logic                   commit;
  logic                   flush;
  logic                   ovf_clr;
  logic                   read_commit;
  logic                   read_pending;
  logic                   fifo_dropped;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CW-1:0]          fifo_count;
  cmd_entry_t             new_entry;
  cmd_entry_t             head;

  // Reset asserts immediately but releases only on a clock edge
  always_ff @(posedge M68K_CLK or negedge M68K_RESET_n) begin
    if (!M68K_RESET_n) rst_sync <= 2'b00;
    else               rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  // Synchronise PI_WR; the top bit holds the previous synced level for edge detect
  always_ff @(posedge M68K_CLK or negedge rst_n) begin
    if (!rst_n) wr_sync <= '0;
    else        wr_sync <= {wr_sync[SYNC_STAGES-1:0], PI_WR};
  end

  // Registered single-cycle pulse on each synced rising edge of PI_WR
  always_ff @(posedge M68K_CLK or negedge rst_n) begin
    if (!rst_n) wr_pulse <= 1'b0;
    else        wr_pulse <= wr_sync[SYNC_STAGES-1] & ~wr_sync[SYNC_STAGES];
  end

  assign commit  = wr_pulse && (reg_sel_e'(PI_A) == REG_ADDR_HI);
  assign flush   = wr_pulse && (reg_sel_e'(PI_A) == REG_STATUS) && PI_D[STATUS_FLUSH_BIT];
  assign ovf_clr = wr_pulse && (reg_sel_e'(PI_A) == REG_STATUS) && PI_D[STATUS_OVF_CLR_BIT];

  // Capture write data and low address ahead of the committing ADDR_HI write
  always_ff @(posedge M68K_CLK or negedge rst_n) begin
    if (!rst_n) begin
      stg_d  <= '0;
      stg_a  <= '0;
      stg_a0 <= 1'b0;
    end else if (wr_pulse) begin
      case (reg_sel_e'(PI_A))
        REG_DATA:    stg_d <= PI_D;
        REG_ADDR_LO: begin
          stg_a  <= PI_D[15:1];
          stg_a0 <= PI_D[0];
        end
        default: ;
      endcase
    end
  end

  assign new_entry = make_entry(stg_a, stg_a0, stg_d, PI_D);

  pistormx_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (M68K_CLK),
    .rst_n   (rst_n),
    .push    (commit),
    .pop     (cmd_ready),
    .flush   (flush),
    .wdata   (new_entry),
    .rdata   (head),
    .dropped (fifo_dropped),
    .count   (fifo_count)
  );

  assign fifo_full   = (fifo_count == FULL_COUNT);
  assign fifo_empty  = (fifo_count == '0);
  assign read_commit = commit & new_entry.rw & ~fifo_dropped;

  assign cmd_valid = ~fifo_empty;
  assign cmd_a     = head.a;
  assign cmd_d     = head.d;
  assign cmd_a0    = head.a0;
  assign cmd_sz    = head.sz;
  assign cmd_rw    = head.rw;

  // A newly committed read stays pending even if older read data returns now
  always_ff @(posedge M68K_CLK or negedge rst_n) begin
    if (!rst_n)           read_pending <= 1'b0;
    else if (flush)       read_pending <= 1'b0;
    else if (read_commit) read_pending <= 1'b1;
    else if (rd_valid)    read_pending <= 1'b0;
  end

  // Latch returned read data whenever the engine presents it
  always_ff @(posedge M68K_CLK or negedge rst_n) begin
    if (!rst_n)        rd_buf <= '0;
    else if (rd_valid) rd_buf <= rd_data;
  end

  // Sticky record of commits lost to a full queue
  always_ff @(posedge M68K_CLK or negedge rst_n) begin
    if (!rst_n)            overflow <= 1'b0;
    else if (ovf_clr)      overflow <= 1'b0;
    else if (fifo_dropped) overflow <= 1'b1;
  end

  // Busy back to the Pi while the queue is full or a read is outstanding
  always_ff @(posedge M68K_CLK or negedge rst_n) begin
    if (!rst_n) PI_TXN_IN_PROGRESS <= 1'b0;
    else        PI_TXN_IN_PROGRESS <= fifo_full | read_pending;
  end

`ifdef PISTORMX_QLEVEL_EN
  assign level = fifo_count;
`endif

endmodule

// File: tb/tb_pistormx_cmd_queue.sv
// Self-checking bench for pistormx_cmd_queue: directed scenarios plus a
// randomised phase, with a scoreboard of expected commands checked by a
// monitor whenever the engine side pops. Build with PISTORMX_QLEVEL_EN to
// also check the level port.
module tb_pistormx_cmd_queue;

  localparam int DEPTH       = 4;
  localparam int SYNC_STAGES = 2;

  typedef struct packed {
    logic [22:0] a;
    logic [15:0] d;
    logic        a0;
    logic        sz;
    logic        rw;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [1:0]  PI_A;
  logic        PI_WR;
  logic [15:0] PI_D;
  logic        busy;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [23:1] cmd_a;
  logic [15:0] cmd_d;
  logic        cmd_a0;
  logic        cmd_sz;
  logic        cmd_rw;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic [15:0] rd_buf;
  logic        overflow;
`ifdef PISTORMX_QLEVEL_EN
  logic [$clog2(DEPTH):0] level;
`endif

  int   tests;
  int   fails;
  exp_t sb[$];
  exp_t got;
  logic [15:0] m_d;
  logic [15:0] m_lo;
  logic [15:0] m_rdbuf;
  bit   m_ovf;
  bit   m_pending;
  bit   rand_ready;

  pistormx_cmd_queue #(
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .M68K_CLK           (clk),
    .M68K_RESET_n       (rst_n),
    .PI_A               (PI_A),
    .PI_WR              (PI_WR),
    .PI_D               (PI_D),
    .PI_TXN_IN_PROGRESS (busy),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_a              (cmd_a),
    .cmd_d              (cmd_d),
    .cmd_a0             (cmd_a0),
    .cmd_sz             (cmd_sz),
    .cmd_rw             (cmd_rw),
    .rd_valid           (rd_valid),
    .rd_data            (rd_data),
    .rd_buf             (rd_buf),
    .overflow           (overflow)
`ifdef PISTORMX_QLEVEL_EN
    ,
    .level              (level)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Random engine back-pressure, changed just after each rising edge
  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      cmd_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: every engine pop must match the oldest expected command
  always @(negedge clk) begin
    if (rst_n && cmd_valid && cmd_ready) begin
      got = {cmd_a, cmd_d, cmd_a0, cmd_sz, cmd_rw};
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("[TB] FAIL pop_unexpected: actual %h required no entry", got);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (got !== e) begin
          fails++;
          $display("[TB] FAIL pop_entry: actual %h required %h", got, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: actual %h required %h", name, actual, expected);
    end
  endtask

  // Expected command: byte address {HI[7:0], LO} halved, lane from LO bit 0
  function automatic exp_t expectEntry(input logic [15:0] hi);
    exp_t        e;
    logic [23:0] byte_addr;
    logic [23:0] word_addr;
    byte_addr = {hi[7:0], m_lo};
    word_addr = byte_addr >> 1;
    e.a  = word_addr[22:0];
    e.d  = m_d;
    e.a0 = m_lo[0];
    e.sz = hi[8];
    e.rw = hi[9];
    return e;
  endfunction

  task automatic piWrite(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    PI_A  = a;
    PI_D  = d;
    PI_WR = 1'b1;
    repeat (6) @(negedge clk);
    PI_WR = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Update the reference model for a Pi register write, then perform it
  task automatic applyStimulus(input logic [1:0] a, input logic [15:0] d);
    exp_t e;
    case (a)
      2'd0: m_d  = d;
      2'd1: m_lo = d;
      2'd2: begin
        e = expectEntry(d);
        if (sb.size() < DEPTH) begin
          sb.push_back(e);
          if (e.rw) m_pending = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end
      default: begin
        if (d[2]) m_ovf = 1'b0;
        if (d[3]) begin
          sb.delete();
          m_pending = 1'b0;
        end
      end
    endcase
    piWrite(a, d);
  endtask

  task automatic postCmd(input logic [15:0] lo, input logic [15:0] data, input logic [15:0] hi);
    applyStimulus(2'd0, data);
    applyStimulus(2'd1, lo);
    applyStimulus(2'd2, hi);
  endtask

  // ADDR_HI commit with a single-cycle engine pop on the exact commit edge
  task automatic alignedCommit(input logic [15:0] hi);
    sb.push_back(expectEntry(hi));
    @(negedge clk);
    PI_A  = 2'd2;
    PI_D  = hi;
    PI_WR = 1'b1;
    repeat (SYNC_STAGES + 1) @(posedge clk);
    #1 cmd_ready = 1'b1;
    @(posedge clk);
    #1 cmd_ready = 1'b0;
    repeat (3) @(negedge clk);
    PI_WR = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic rdPulse(input logic [15:0] d);
    @(negedge clk);
    rd_valid = 1'b1;
    rd_data  = d;
    @(negedge clk);
    rd_valid = 1'b0;
    m_rdbuf  = d;
    m_pending = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic waitDrain(input string name, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 64'(sb.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic resetModel();
    sb.delete();
    m_d = '0; m_lo = '0; m_rdbuf = '0;
    m_ovf = 1'b0; m_pending = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0;
    rand_ready = 1'b0;
    cmd_ready = 1'b0; rd_valid = 1'b0; rd_data = '0;
    PI_A = '0; PI_D = '0; PI_WR = 1'b0;
    resetModel();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    checkOutput("reset_cmd_valid", 64'(cmd_valid), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_overflow", 64'(overflow), 64'd0);
    checkOutput("reset_rd_buf", 64'(rd_buf), 64'd0);

    // Single posted write consumed immediately
    cmd_ready = 1'b1;
    postCmd(16'h0A01, 16'h1234, 16'h0000);
    waitDrain("post_write_drain", 50);
    checkOutput("post_write_idle", 64'(cmd_valid), 64'd0);

    // Fill past capacity with the engine stalled
    cmd_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      postCmd(16'(16'h0100 + i * 2), 16'(16'h1111 * (i + 1)), 16'(i));
      if (i == DEPTH - 1) begin
        checkOutput("fill_busy", 64'(busy), 64'(sb.size() == DEPTH));
        checkOutput("fill_no_ovf_yet", 64'(overflow), 64'(m_ovf));
      end
    end
    checkOutput("fill_overflow", 64'(overflow), 64'(m_ovf));
`ifdef PISTORMX_QLEVEL_EN
    checkOutput("fill_level", 64'(level), 64'(sb.size()));
`endif
    applyStimulus(2'd3, 16'h0004);
    checkOutput("ovf_clear", 64'(overflow), 64'(m_ovf));
    cmd_ready = 1'b1;
    waitDrain("fill_drain", 100);
    checkOutput("fill_drain_busy", 64'(busy), 64'd0);

    // Commit into a full queue on the same edge as a pop
    cmd_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) postCmd(16'(16'h2000 + i * 4), 16'(16'hA000 + i), 16'h0011);
    applyStimulus(2'd0, 16'h5A5A);
    applyStimulus(2'd1, 16'h3003);
    alignedCommit(16'h0122);
    checkOutput("simul_overflow", 64'(overflow), 64'd0);
    checkOutput("simul_busy_full", 64'(busy), 64'd1);
`ifdef PISTORMX_QLEVEL_EN
    checkOutput("simul_level", 64'(level), 64'(DEPTH));
`endif
    cmd_ready = 1'b1;
    waitDrain("simul_drain", 100);

    // Two writes then a read, drained in order; busy until data returns
    postCmd(16'h4000, 16'h0001, 16'h0010);
    postCmd(16'h4002, 16'h0002, 16'h0010);
    postCmd(16'h4005, 16'h0000, 16'h0200);
    waitDrain("read_order_drain", 100);
    checkOutput("read_busy", 64'(busy), 64'd1);
    rdPulse(16'hBEEF);
    checkOutput("read_rd_buf", 64'(rd_buf), 64'(m_rdbuf));
    checkOutput("read_busy_clear", 64'(busy), 64'd0);

    // Flush drops queued entries and the outstanding read
    cmd_ready = 1'b0;
    postCmd(16'h6000, 16'h1111, 16'h0001);
    postCmd(16'h6002, 16'h2222, 16'h0001);
    postCmd(16'h6004, 16'h3333, 16'h0201);
    checkOutput("flush_pre_valid", 64'(cmd_valid), 64'd1);
    checkOutput("flush_pre_busy", 64'(busy), 64'd1);
    applyStimulus(2'd3, 16'h0008);
    checkOutput("flush_valid", 64'(cmd_valid), 64'd0);
    checkOutput("flush_busy", 64'(busy), 64'(m_pending));

    // Reset with three entries queued
    postCmd(16'h7000, 16'h0101, 16'h0002);
    postCmd(16'h7002, 16'h0202, 16'h0002);
    postCmd(16'h7004, 16'h0303, 16'h0202);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    resetModel();
    checkOutput("midq_reset_valid", 64'(cmd_valid), 64'd0);
    checkOutput("midq_reset_busy", 64'(busy), 64'd0);
    checkOutput("midq_reset_rd_buf", 64'(rd_buf), 64'd0);
`ifdef PISTORMX_QLEVEL_EN
    checkOutput("midq_reset_level", 64'(level), 64'd0);
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Randomised traffic with random engine back-pressure
    rand_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      logic [15:0] hi;
      int n;
      hi = {6'd0, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 8'($urandom)};
      n = 0;
      while (sb.size() >= DEPTH && n < 200) begin
        @(negedge clk);
        n++;
      end
      postCmd(16'($urandom), 16'($urandom), hi);
      if (hi[9]) begin
        waitDrain("rand_read_pop", 300);
        rdPulse(16'($urandom));
        checkOutput("rand_rd_buf", 64'(rd_buf), 64'(m_rdbuf));
        checkOutput("rand_busy_clear", 64'(busy), 64'(m_pending));
      end else if ($urandom_range(0, 5) == 0) begin
        rdPulse(16'($urandom));
        checkOutput("rand_unsolicited_rd_buf", 64'(rd_buf), 64'(m_rdbuf));
      end
    end
    waitDrain("rand_final_drain", 400);
    rand_ready = 1'b0;
    #2 cmd_ready = 1'b0;
    checkOutput("rand_overflow", 64'(overflow), 64'(m_ovf));
    checkOutput("final_idle", 64'(cmd_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
